// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg
// Shared definitions for the UART receive buffer: the 2-bit receive error
// codes produced by the RX FSM and the packed FIFO entry layout.
package uart_rx_pkg;

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_FRM  = 2'b01;
    localparam logic [1:0] ERR_PAR  = 2'b10;
    localparam logic [1:0] ERR_FULL = 2'b11;

    // One FIFO entry: error code in the upper two bits, character below.
    typedef struct packed {
        logic [1:0] err;
        logic [7:0] data;
    } rx_entry_t;

endpackage

// File: rtl/uart_rxbuf_mem.sv
// uart_rxbuf_mem
// DEPTH x 10-bit register array backing the receive FIFO.
// Ports:
//   clk      - clock for the write port
//   wr_en    - store wr_data at wr_addr on the next edge
//   wr_addr  - write address
//   wr_data  - entry to store
//   rd_addr  - read address
//   rd_data  - asynchronous read of mem[rd_addr]
module uart_rxbuf_mem
    import uart_rx_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  rx_entry_t     wr_data,
    input  logic [AW-1:0] rd_addr,
    output rx_entry_t     rd_data
);

    rx_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rxbuf.sv
// uart_rxbuf
// Receive buffer behind the UART RX FSM: first-word-fall-through FIFO of
// {err, data} entries, space feedback to the FSM, pop port for the register
// block, threshold/timeout interrupts and sticky error status.
// Ports:
//   app_clk, reset            - clock and synchronous active-high reset
//   cfg_rx_enable             - low flushes the buffer back to reset state
//   cfg_thresh, cfg_timeout   - interrupt threshold and idle timeout (0 = off)
//   rx_wr_lvl, rx_data, rx_err- write level, character and error from RX FSM
//   fifo_aval                 - at least one free entry
//   rd_en, rd_data, rd_err, rd_valid - FWFT pop interface
//   fifo_cnt                  - occupancy 0..DEPTH
//   irq_thresh, irq_timeout   - level / sticky interrupts
//   sts_frm_err, sts_par_err, sts_ovr_err, err_clr - sticky status and clear
module uart_rxbuf
    import uart_rx_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          app_clk,
    input  logic          reset,
    input  logic          cfg_rx_enable,
    input  logic [AW-1:0] cfg_thresh,
    input  logic [15:0]   cfg_timeout,
    input  logic          rx_wr_lvl,
    input  logic [7:0]    rx_data,
    input  logic [1:0]    rx_err,
    output logic          fifo_aval,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic [1:0]    rd_err,
    output logic          rd_valid,
    output logic [AW:0]   fifo_cnt,
    output logic          irq_thresh,
    output logic          irq_timeout,
    output logic          sts_frm_err,
    output logic          sts_par_err,
    output logic          sts_ovr_err,
    input  logic          err_clr
);

    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic          rx_wr_d;
    logic          wr_pulse;
    logic          wr_req;
    rx_entry_t     wr_entry;
    rx_entry_t     rd_entry;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic [AW:0]   cnt_next;
    logic [15:0]   tmo_cnt;
    logic          full;
    logic          pop;
    logic          wr_accept;
    logic          wr_reject;
    logic          tmo_hit;

    assign wr_pulse  = rx_wr_lvl & ~rx_wr_d;
    assign full      = (cnt == CNT_FULL);
    assign rd_valid  = (cnt != '0);
    assign pop       = rd_en & rd_valid;
    // A write into a full FIFO still fits when the head leaves in the same cycle.
    assign wr_accept = wr_req & (~full | pop);
    assign wr_reject = wr_req & full & ~pop;
    assign tmo_hit   = (cfg_timeout != 16'd0) && (tmo_cnt == cfg_timeout) && rd_valid;

    assign fifo_cnt   = cnt;
    assign irq_thresh = (cnt > {1'b0, cfg_thresh});
    assign rd_data    = rd_entry.data;
    assign rd_err     = rd_entry.err;

    always_comb begin
        cnt_next = cnt;
        if (wr_accept && !pop) begin
            cnt_next = cnt + 1'b1;
        end else if (pop && !wr_accept) begin
            cnt_next = cnt - 1'b1;
        end
    end

    // rx_wr_d keeps following the level during a flush so that re-enabling
    // with the level already high does not look like a new character.
    always_ff @(posedge app_clk) begin
        if (reset) begin
            rx_wr_d <= 1'b0;
        end else begin
            rx_wr_d <= rx_wr_lvl;
        end
    end

    // The detected edge and its entry are registered once before reaching the
    // FIFO, so the entry appears two cycles after the level rises.
    always_ff @(posedge app_clk) begin
        wr_entry <= '{err: rx_err, data: rx_data};
    end

    always_ff @(posedge app_clk) begin
        if (reset || !cfg_rx_enable) begin
            wr_req      <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cnt         <= '0;
            fifo_aval   <= 1'b1;
            tmo_cnt     <= 16'd0;
            irq_timeout <= 1'b0;
            sts_frm_err <= 1'b0;
            sts_par_err <= 1'b0;
            sts_ovr_err <= 1'b0;
        end else begin
            wr_req <= wr_pulse;
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            cnt       <= cnt_next;
            fifo_aval <= (cnt_next != CNT_FULL);

            // Idle counter only runs while something sits unread.
            if (wr_accept || pop || !rd_valid) begin
                tmo_cnt <= 16'd0;
            end else if (tmo_cnt != 16'hFFFF) begin
                tmo_cnt <= tmo_cnt + 16'd1;
            end

            if (pop) begin
                irq_timeout <= 1'b0;
            end else if (tmo_hit) begin
                irq_timeout <= 1'b1;
            end else if (err_clr) begin
                irq_timeout <= 1'b0;
            end

            // New error events win over a coincident clear.
            sts_frm_err <= (wr_accept && wr_entry.err == ERR_FRM) || (sts_frm_err && !err_clr);
            sts_par_err <= (wr_accept && wr_entry.err == ERR_PAR) || (sts_par_err && !err_clr);
            sts_ovr_err <= (wr_accept && wr_entry.err == ERR_FULL) || wr_reject
                           || (sts_ovr_err && !err_clr);
        end
    end

    uart_rxbuf_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (app_clk),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr),
        .rd_data (rd_entry)
    );

endmodule

// File: tb/tb_uart_rxbuf.sv
// tb_uart_rxbuf
// Directed self-checking bench for uart_rxbuf (DEPTH 16): single character,
// fill/overrun, full with simultaneous pop and write, error status, timeout
// interrupt and flush behaviour.
module tb_uart_rxbuf;

    logic        app_clk;
    logic        reset;
    logic        cfg_rx_enable;
    logic [3:0]  cfg_thresh;
    logic [15:0] cfg_timeout;
    logic        rx_wr_lvl;
    logic [7:0]  rx_data;
    logic [1:0]  rx_err;
    logic        fifo_aval;
    logic        rd_en;
    logic [7:0]  rd_data;
    logic [1:0]  rd_err;
    logic        rd_valid;
    logic [4:0]  fifo_cnt;
    logic        irq_thresh;
    logic        irq_timeout;
    logic        sts_frm_err;
    logic        sts_par_err;
    logic        sts_ovr_err;
    logic        err_clr;

    int checks = 0;
    int errors = 0;

    uart_rxbuf #(
        .DEPTH (16),
        .AW    (4)
    ) dut (
        .app_clk       (app_clk),
        .reset         (reset),
        .cfg_rx_enable (cfg_rx_enable),
        .cfg_thresh    (cfg_thresh),
        .cfg_timeout   (cfg_timeout),
        .rx_wr_lvl     (rx_wr_lvl),
        .rx_data       (rx_data),
        .rx_err        (rx_err),
        .fifo_aval     (fifo_aval),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .rd_err        (rd_err),
        .rd_valid      (rd_valid),
        .fifo_cnt      (fifo_cnt),
        .irq_thresh    (irq_thresh),
        .irq_timeout   (irq_timeout),
        .sts_frm_err   (sts_frm_err),
        .sts_par_err   (sts_par_err),
        .sts_ovr_err   (sts_ovr_err),
        .err_clr       (err_clr)
    );

    initial app_clk = 1'b0;
    always #5 app_clk = ~app_clk;

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge app_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One character: level high for one cycle, entry visible when this returns.
    task automatic applyStimulus(input logic [7:0] data, input logic [1:0] err);
        rx_data   = data;
        rx_err    = err;
        rx_wr_lvl = 1'b1;
        tick();
        rx_wr_lvl = 1'b0;
        tick();
    endtask

    task automatic popEntry();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        cfg_rx_enable = 1'b1;
        cfg_thresh    = 4'd4;
        cfg_timeout   = 16'd0;
        rx_wr_lvl     = 1'b0;
        rx_data       = 8'h00;
        rx_err        = 2'b00;
        rd_en         = 1'b0;
        err_clr       = 1'b0;
        repeat (3) tick();

        // Reset values
        checkOutput("reset_cnt", 16'(fifo_cnt), 16'd0);
        checkOutput("reset_valid", 16'(rd_valid), 16'd0);
        checkOutput("reset_aval", 16'(fifo_aval), 16'd1);
        checkOutput("reset_irq", 16'({irq_thresh, irq_timeout}), 16'd0);
        checkOutput("reset_sts", 16'({sts_frm_err, sts_par_err, sts_ovr_err}), 16'd0);
        reset = 1'b0;
        tick();

        // Single character with a long level: exactly one entry, latency 2
        rx_data   = 8'hA5;
        rx_err    = 2'b00;
        rx_wr_lvl = 1'b1;
        tick();
        checkOutput("single_lat1_valid", 16'(rd_valid), 16'd0);
        tick();
        checkOutput("single_lat2_valid", 16'(rd_valid), 16'd1);
        checkOutput("single_data", 16'(rd_data), 16'h00A5);
        repeat (18) tick();
        rx_wr_lvl = 1'b0;
        tick();
        checkOutput("single_cnt", 16'(fifo_cnt), 16'd1);
        checkOutput("single_sts", 16'({sts_frm_err, sts_par_err, sts_ovr_err}), 16'd0);
        popEntry();
        checkOutput("single_pop_valid", 16'(rd_valid), 16'd0);

        // Fill to 16, check threshold boundary, then overrun
        for (int i = 0; i < 16; i++) begin
            applyStimulus(8'h20 + 8'(i), 2'b00);
            if (i == 3) checkOutput("thresh_at4", 16'(irq_thresh), 16'd0);
            if (i == 4) checkOutput("thresh_at5", 16'(irq_thresh), 16'd1);
        end
        checkOutput("fill_cnt", 16'(fifo_cnt), 16'd16);
        checkOutput("fill_aval", 16'(fifo_aval), 16'd0);
        checkOutput("fill_ovr_before", 16'(sts_ovr_err), 16'd0);
        applyStimulus(8'h11, 2'b00);
        checkOutput("overrun_cnt", 16'(fifo_cnt), 16'd16);
        checkOutput("overrun_sts", 16'(sts_ovr_err), 16'd1);
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("drain_%0d", i), 16'(rd_data), 16'(8'h20 + 8'(i)));
            popEntry();
        end
        checkOutput("drain_empty", 16'(rd_valid), 16'd0);
        checkOutput("drain_aval", 16'(fifo_aval), 16'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checkOutput("ovr_cleared", 16'(sts_ovr_err), 16'd0);

        // Full with a simultaneous pop and write
        for (int i = 0; i < 16; i++) applyStimulus(8'h40 + 8'(i), 2'b00);
        rx_data   = 8'h77;
        rx_wr_lvl = 1'b1;
        tick();
        rx_wr_lvl = 1'b0;
        rd_en     = 1'b1;
        tick();
        rd_en = 1'b0;
        checkOutput("fullrw_cnt", 16'(fifo_cnt), 16'd16);
        checkOutput("fullrw_aval", 16'(fifo_aval), 16'd0);
        checkOutput("fullrw_ovr", 16'(sts_ovr_err), 16'd0);
        for (int i = 1; i < 16; i++) begin
            checkOutput($sformatf("fullrw_head_%0d", i), 16'(rd_data), 16'(8'h40 + 8'(i)));
            popEntry();
        end
        checkOutput("fullrw_tail", 16'(rd_data), 16'h0077);
        popEntry();
        checkOutput("fullrw_empty", 16'(fifo_cnt), 16'd0);

        // Error codes, status and clear priority
        applyStimulus(8'h55, 2'b01);
        applyStimulus(8'h66, 2'b10);
        checkOutput("err_sts", 16'({sts_frm_err, sts_par_err, sts_ovr_err}), 16'b110);
        checkOutput("err_head1", 16'(rd_err), 16'd1);
        popEntry();
        checkOutput("err_head2", 16'(rd_err), 16'd2);
        checkOutput("err_head2_data", 16'(rd_data), 16'h0066);
        popEntry();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checkOutput("err_clr", 16'({sts_frm_err, sts_par_err}), 16'd0);
        rx_data   = 8'h5A;
        rx_err    = 2'b01;
        rx_wr_lvl = 1'b1;
        tick();
        rx_wr_lvl = 1'b0;
        err_clr   = 1'b1;
        tick();
        err_clr = 1'b0;
        checkOutput("err_set_beats_clr", 16'(sts_frm_err), 16'd1);
        popEntry();
        rx_err = 2'b00;

        // Timeout: write accepted, then count 100 idle edges
        cfg_timeout = 16'd100;
        rx_data     = 8'hC3;
        rx_wr_lvl   = 1'b1;
        tick();
        rx_wr_lvl = 1'b0;
        tick();
        checkOutput("tmo_written", 16'(fifo_cnt), 16'd1);
        repeat (100) tick();
        checkOutput("tmo_not_yet", 16'(irq_timeout), 16'd0);
        tick();
        checkOutput("tmo_fired", 16'(irq_timeout), 16'd1);
        repeat (5) tick();
        checkOutput("tmo_sticky", 16'(irq_timeout), 16'd1);
        popEntry();
        checkOutput("tmo_pop_clear", 16'(irq_timeout), 16'd0);
        cfg_timeout = 16'd0;
        applyStimulus(8'hC4, 2'b00);
        repeat (200) tick();
        checkOutput("tmo_disabled", 16'(irq_timeout), 16'd0);
        popEntry();

        // Flush with 5 entries, then re-enable with the level already high
        for (int i = 0; i < 5; i++) applyStimulus(8'h80 + 8'(i), 2'b01);
        checkOutput("flush_pre_cnt", 16'(fifo_cnt), 16'd5);
        cfg_rx_enable = 1'b0;
        rx_data       = 8'hEE;
        rx_wr_lvl     = 1'b1;
        tick();
        checkOutput("flush_cnt", 16'(fifo_cnt), 16'd0);
        checkOutput("flush_aval", 16'(fifo_aval), 16'd1);
        checkOutput("flush_sts", 16'(sts_frm_err), 16'd0);
        cfg_rx_enable = 1'b1;
        repeat (4) tick();
        checkOutput("reenable_nowrite", 16'(fifo_cnt), 16'd0);
        rx_wr_lvl = 1'b0;
        tick();
        applyStimulus(8'h99, 2'b00);
        checkOutput("reenable_write", 16'(rd_data), 16'h0099);
        checkOutput("reenable_cnt", 16'(fifo_cnt), 16'd1);

        // Reset mid-stream discards everything
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("midreset_cnt", 16'(fifo_cnt), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rxbuf.md
# uart_rxbuf

Receive buffer stage directly downstream of the UART RX FSM. It captures each received character plus its 2-bit error code into a first-word-fall-through FIFO, and returns FIFO space availability to the FSM. It exposes a pop interface to the register block, along with threshold/timeout interrupts and sticky error status. All logic runs in the application clock domain; the RX FSM's write strobe and data arrive already synchronized.

## Interface
- DEPTH, 16, FIFO entries; power of 2, at least 4
- AW, 4, log2(DEPTH)
- app_clk  in  1  block clock
- reset  in  1  synchronous, active-high reset
- cfg_rx_enable  in  1  0 = flush: all state returns to reset values
- cfg_thresh  in  AW  irq_thresh asserts when fifo_cnt > cfg_thresh
- cfg_timeout  in  16  idle timeout in app_clk cycles; 0 disables
- rx_wr_lvl  in  1  synchronized RX FSM fifo_wr; a level, possibly high for many cycles
- rx_data  in  8  received character, stable while rx_wr_lvl is high
- rx_err  in  2  00 ok, 01 framing, 10 parity, 11 fifo-full at start bit
- fifo_aval  out  1  to RX FSM: at least one free entry
- rd_en  in  1  pop head entry; ignored when empty
- rd_data  out  8  head character (FWFT)
- rd_err  out  2  head error code
- rd_valid  out  1  FIFO non-empty
- fifo_cnt  out  AW+1  occupancy, 0..DEPTH
- irq_thresh  out  1  level interrupt
- irq_timeout  out  1  sticky interrupt
- sts_frm_err, sts_par_err, sts_ovr_err  out  1 each  sticky status bits
- err_clr  in  1  clears all three sticky status bits and irq_timeout

## Operation
- Write detect: registered rx_wr_d; wr_pulse = rx_wr_lvl & ~rx_wr_d. Exactly one write attempt per rising edge of rx_wr_lvl.
- Write accept: the entry {rx_err, rx_data} is stored at wr_ptr when wr_pulse is high and either (fifo_cnt < DEPTH) or (rd_en & rd_valid) in the same cycle.
- Write reject: a wr_pulse with the FIFO full and no pop drops the character and sets sts_ovr_err.
- Pop: rd_en & rd_valid advances rd_ptr. rd_en while empty has no effect.
- Pointers: AW-bit, wrap modulo DEPTH. fifo_cnt is +1 on write only, -1 on pop only, unchanged on both.
- Status from stored entries: each accepted write with rx_err==01 sets sts_frm_err; 10 sets sts_par_err; 11 sets sts_ovr_err. The entry is still stored.
- fifo_aval = (fifo_cnt != DEPTH), registered from next-state count.
- irq_thresh = (fifo_cnt > cfg_thresh), combinational from the count register.
- Timeout counter (16-bit):
  - Cleared on accepted write, on pop, and while empty.
  - Otherwise increments, saturating at 16'hFFFF.
  - When cfg_timeout != 0 and the counter equals cfg_timeout with the FIFO non-empty, irq_timeout sets.
  - irq_timeout clears on pop, err_clr, or flush.
- Sticky bits: set has priority over err_clr in the same cycle.
- cfg_rx_enable low acts like reset, except that rx_wr_d keeps tracking rx_wr_lvl so no false edge is seen on re-enable.

## Timing
- Reset/flush values: pointers 0, fifo_cnt 0, rd_valid 0, fifo_aval 1, irq_thresh 0 (with reset cfg), irq_timeout 0, all sticky bits 0, rx_wr_d 0 (reset only).
- rd_data/rd_err: combinational read of mem[rd_ptr]. The value is undefined while rd_valid is 0.
- Write latency: rising edge of rx_wr_lvl at cycle N; entry visible on rd_valid/rd_data at cycle N+2 (edge register, then memory/count update).
- Pop: rd_en at cycle N; the next head appears at cycle N+1.
- Full with simultaneous pop and write: count stays DEPTH, fifo_aval stays 0, no overrun.
- Reset mid-stream takes effect on the next edge; in-flight data is discarded.

## Structure
- Package uart_rx_pkg:
  - localparams ERR_OK=2'b00, ERR_FRM=2'b01, ERR_PAR=2'b10, ERR_FULL=2'b11.
  - typedef rx_entry_t = {err[1:0], data[7:0]}.
- Sub-module uart_rxbuf_mem: DEPTH x 10 register array, one synchronous write port, one asynchronous read port. Pointers and control stay in uart_rxbuf.

## Test plan
- Single char: rx_data=8'hA5, rx_err=00, rx_wr_lvl high 20 cycles → exactly one entry; rd_data=A5, fifo_cnt=1, no status bits; pop → rd_valid=0.
- Fill/overrun (DEPTH=16): 16 writes → fifo_aval=0, fifo_cnt=16; 17th write (8'h11) dropped, sts_ovr_err=1; 16 pops return the first 16 bytes in order.
- Full plus simultaneous pop and write → fifo_cnt stays 16, new byte at tail, sts_ovr_err stays 0.
- Errors: writes with rx_err=01 then 10 → sts_frm_err=1, sts_par_err=1, rd_err=01 then 10; err_clr coincident with a new 01 write → sts_frm_err stays 1.
- Timeout: cfg_timeout=100, one write, no pop → irq_timeout rises exactly 100 cycles after the count resets; pop clears it; cfg_timeout=0 → never fires.
- Flush: cfg_rx_enable low for 1 cycle with 5 entries → fifo_cnt=0, fifo_aval=1; re-enable while rx_wr_lvl is already high → no write.
